// File: rtl/bip_pkg.sv
// Shared BIP1 debug-path definitions: memory geometry,
// byte width and the dumper state encoding.
package bip_pkg;

   localparam int BYTE_WIDTH     = 8;
   localparam int BIP_RAM_WIDTH  = 16;
   localparam int BIP_RAM_DEPTH  = 1024;
   localparam int BIP_ADDR_WIDTH = 11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_LATCH   = 3'd2,
      ST_SEND_HI = 3'd3,
      ST_WAIT_HI = 3'd4,
      ST_SEND_LO = 3'd5,
      ST_WAIT_LO = 3'd6,
      ST_DONE    = 3'd7
   } state_t;

endpackage

// File: rtl/data_mem_dumper_if.sv
// Bundle between the dumper, the data_mem read port,
// the uart_tx handshake and the debug controller.
interface data_mem_dumper_if #(
   parameter int RAM_WIDTH  = bip_pkg::BIP_RAM_WIDTH,
   parameter int ADDR_WIDTH = bip_pkg::BIP_ADDR_WIDTH
);
   import bip_pkg::*;

   logic                  i_start;
   logic [ADDR_WIDTH-1:0] i_base_addr;
   logic [ADDR_WIDTH-1:0] i_count;
   logic [ADDR_WIDTH-1:0] o_addr;
   logic [RAM_WIDTH-1:0]  i_mem_data;
   logic [BYTE_WIDTH-1:0] o_tx_data;
   logic                  o_tx_start;
   logic                  i_tx_done;
   logic                  o_busy;
   logic                  o_done;

   modport master (
      input  i_start, i_base_addr, i_count,
      input  i_mem_data, i_tx_done,
      output o_addr, o_tx_data, o_tx_start,
      output o_busy, o_done
   );

   modport slave (
      output i_start, i_base_addr, i_count,
      output i_mem_data, i_tx_done,
      input  o_addr, o_tx_data, o_tx_start,
      input  o_busy, o_done
   );

endinterface

// File: rtl/data_mem_dumper.sv
// Walks a data_mem range and streams each word to uart_tx
// as two bytes, high byte first.
module data_mem_dumper
   import bip_pkg::*;
#(
   parameter int RAM_WIDTH  = BIP_RAM_WIDTH,
   parameter int RAM_DEPTH  = BIP_RAM_DEPTH,
   parameter int ADDR_WIDTH = BIP_ADDR_WIDTH
) (
   input logic               i_clk,
   input logic               i_rst,
   data_mem_dumper_if.master bus
);

   localparam logic [ADDR_WIDTH:0] DEPTH_W =
      (ADDR_WIDTH+1)'(RAM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
      ADDR_WIDTH'(RAM_DEPTH-1);
   localparam logic [ADDR_WIDTH:0] ONE_W =
      (ADDR_WIDTH+1)'(1);

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH:0]   remain_q;
   logic [RAM_WIDTH-1:0]  word_q;
   logic [BYTE_WIDTH-1:0] tx_data_q;
   logic [ADDR_WIDTH:0]   count_w;
   logic [ADDR_WIDTH-1:0] addr_inc;

   assign count_w  = {1'b0, bus.i_count};
   // High address bits are cleared so the walk wraps at RAM_DEPTH.
   assign addr_inc = (addr_q + ADDR_WIDTH'(1)) & ADDR_MASK;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         remain_q  <= '0;
         word_q    <= '0;
         tx_data_q <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (bus.i_start) begin
                  if (bus.i_count != '0) begin
                     addr_q   <= bus.i_base_addr;
                     remain_q <= (count_w > DEPTH_W) ?
                                 DEPTH_W : count_w;
                     state    <= ST_READ;
                  end else begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_READ:  state <= ST_LATCH;
            ST_LATCH: begin
               word_q    <= bus.i_mem_data;
               tx_data_q <=
                  bus.i_mem_data[RAM_WIDTH-1 -: BYTE_WIDTH];
               state     <= ST_SEND_HI;
            end
            ST_SEND_HI: state <= ST_WAIT_HI;
            ST_WAIT_HI: begin
               if (bus.i_tx_done) begin
                  tx_data_q <= word_q[BYTE_WIDTH-1:0];
                  state     <= ST_SEND_LO;
               end
            end
            ST_SEND_LO: state <= ST_WAIT_LO;
            ST_WAIT_LO: begin
               if (bus.i_tx_done) begin
                  if (remain_q == ONE_W) begin
                     state <= ST_DONE;
                  end else begin
                     addr_q   <= addr_inc;
                     remain_q <= remain_q - ONE_W;
                     state    <= ST_READ;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_addr     = addr_q;
   assign bus.o_tx_data  = tx_data_q;
   assign bus.o_tx_start = (state == ST_SEND_HI) ||
                           (state == ST_SEND_LO);
   assign bus.o_busy     = (state != ST_IDLE);
   assign bus.o_done     = (state == ST_DONE);

endmodule
